// File: rtl/pt_srv_pkg.sv
// pt_srv_pkg: shared constants and FSM state encoding for the point server.
package pt_srv_pkg;

    localparam int IMG_W_DEF   = 640;
    localparam int IMG_H_DEF   = 480;
    localparam int MEM_LAT_DEF = 2;
    localparam int ADDR_W      = 19;
    localparam int CNT_W       = 16;
    localparam int LAT_W       = 3;   // holds MEM_LAT up to 7

    // One-hot server states
    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_ADDR      = 5'b00010,
        ST_READ      = 5'b00100,
        ST_WAIT_DATA = 5'b01000,
        ST_RELEASE   = 5'b10000
    } pt_state_e;

endpackage

// File: rtl/pt_server_if.sv
// pt_server_if: point request/response handshake plus the pixel memory port.
// slave = the server side, master = the initiator / memory model side.
interface pt_server_if;
    import pt_srv_pkg::*;

    logic              pt_req;
    logic [9:0]        pt_coords_x;
    logic [9:0]        pt_coords_y;
    logic              pt_valid;
    logic              pt_value;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rdata;

    modport slave (
        input  pt_req, pt_coords_x, pt_coords_y, mem_rdata,
        output pt_valid, pt_value, mem_rd, mem_addr
    );

    modport master (
        output pt_req, pt_coords_x, pt_coords_y, mem_rdata,
        input  pt_valid, pt_value, mem_rd, mem_addr
    );

endinterface

// File: rtl/pt_addr_map.sv
// pt_addr_map: registered coordinate-to-address multiply-add and out-of-range
// flag. Loads on load_i and holds otherwise; one cycle of latency.
module pt_addr_map
    import pt_srv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [9:0]        x_i,
    input  logic [9:0]        y_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              oor_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              oor_q, oor_d;

    // Next address/flag: computed from the live coordinates when loading
    always_comb begin
        addr_d = addr_q;
        oor_d  = oor_q;
        if (load_i) begin
            // Address wraps to 19 bits for coordinates past the image
            addr_d = ADDR_W'(32'(y_i) * 32'(IMG_W) + 32'(x_i));
            oor_d  = (32'(x_i) >= 32'(IMG_W)) || (32'(y_i) >= 32'(IMG_H));
        end
    end

    // Address/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            oor_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            oor_q  <= oor_d;
        end
    end

    assign addr_o = addr_q;
    assign oor_o  = oor_q;

endmodule

// File: rtl/pt_server.sv
// pt_server: single-pixel read server over a fixed-latency binary image memory.
// Optional build macro PT_SRV_RANGE_CHECK_EN: out-of-range requests are
// answered with OOR_VALUE straight from ADDR, without a memory read.
//
// state      | meaning
// IDLE       | waiting for pt_req; coordinates captured on acceptance
// ADDR       | address/range flag available; mem_addr loaded
// READ       | mem_rd strobe asserted for one cycle
// WAIT_DATA  | counting memory latency; pixel sampled on terminal count
// RELEASE    | pt_valid pulsed on entry; wait for pt_req low
module pt_server
    import pt_srv_pkg::*;
#(
    parameter int   IMG_W     = IMG_W_DEF,
    parameter int   IMG_H     = IMG_H_DEF,
    parameter int   MEM_LAT   = MEM_LAT_DEF,
    parameter logic OOR_VALUE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    pt_server_if.slave       bus,
    output logic [CNT_W-1:0] oor_cnt
);

    pt_state_e         state_q, state_d;
    logic              pt_valid_q, pt_valid_d;
    logic              pt_value_q, pt_value_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  oor_cnt_q, oor_cnt_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

    logic              map_load;
    logic [ADDR_W-1:0] map_addr;
    logic              map_oor;

    assign map_load = (state_q == ST_IDLE) && bus.pt_req;

    pt_addr_map #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_addr_map (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (map_load),
        .x_i    (bus.pt_coords_x),
        .y_i    (bus.pt_coords_y),
        .addr_o (map_addr),
        .oor_o  (map_oor)
    );

    // Next-state and next-output decode for the request sequence
    always_comb begin
        state_d    = state_q;
        pt_valid_d = 1'b0;
        pt_value_d = pt_value_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        oor_cnt_d  = oor_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.pt_req) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                mem_addr_d = map_addr;
                if (map_oor && (oor_cnt_q != '1)) oor_cnt_d = oor_cnt_q + CNT_W'(1);
`ifdef PT_SRV_RANGE_CHECK_EN
                if (map_oor) begin
                    pt_value_d = OOR_VALUE;
                    pt_valid_d = 1'b1;
                    state_d    = ST_RELEASE;
                end else begin
                    mem_rd_d = 1'b1;
                    state_d  = ST_READ;
                end
`else
                mem_rd_d = 1'b1;
                state_d  = ST_READ;
`endif
            end
            ST_READ: begin
                lat_cnt_d = LAT_W'(MEM_LAT);
                state_d   = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (lat_cnt_q == LAT_W'(1)) begin
                    lat_cnt_d  = '0;
                    pt_value_d = bus.mem_rdata;
                    pt_valid_d = 1'b1;
                    state_d    = ST_RELEASE;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!bus.pt_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pt_valid_q <= 1'b0;
            pt_value_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            oor_cnt_q  <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pt_valid_q <= pt_valid_d;
            pt_value_q <= pt_value_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            oor_cnt_q  <= oor_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign bus.pt_valid = pt_valid_q;
    assign bus.pt_value = pt_value_q;
    assign bus.mem_rd   = mem_rd_q;
    assign bus.mem_addr = mem_addr_q;
    assign oor_cnt      = oor_cnt_q;

endmodule

// File: tb/tb_pt_server.sv
// tb_pt_server: randomized scoreboard bench for pt_server. The driver pushes
// expected reads/responses computed from image geometry; monitors compare.
// Build with PT_SRV_RANGE_CHECK_EN defined to exercise the range-check path.
module tb_pt_server;

    localparam int W   = 640;
    localparam int H   = 480;
    localparam int LAT = 2;

    typedef struct { int t; int addr; } rd_e;
    typedef struct { int t; int val; int cnt; } rsp_e;
    typedef struct { int t; int val; } mem_e;

    logic        clk;
    logic        rst_n;
    logic [15:0] oor_cnt;
    int          cyc;
    int          tests;
    int          fails;
    int          n_valid;
    int          oor_model;
    int          last_val;

    rd_e  rd_q[$];
    rsp_e rsp_q[$];
    mem_e pend[$];

    pt_server_if bus_if();

    pt_server dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus_if),
        .oor_cnt (oor_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pixel(input int a);
        logic [31:0] h;
        if (a == 1290) return 1;
        h = 32'(a) * 32'h9E37_79B1;
        return int'(h[16] ^ h[23]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: address is row-major y*W+x wrapped to 19 bits; a read issues
    // two cycles after acceptance and the answer arrives LAT+3 after it.
    function automatic void model_issue(input int t, input int x, input int y);
        int a;
        bit oor;
        a   = (y * W + x) % (1 << 19);
        oor = (x >= W) || (y >= H);
        if (oor && oor_model < 65535) oor_model++;
`ifdef PT_SRV_RANGE_CHECK_EN
        if (oor) begin
            rsp_q.push_back('{t + 2, 0, oor_model});
            return;
        end
`endif
        rd_q.push_back('{t + 2, a});
        rsp_q.push_back('{t + 3 + LAT, pixel(a), oor_model});
    endfunction

    // Memory model: answers each read exactly LAT cycles later, noise otherwise
    always @(negedge clk) begin
        if (pend.size() > 0 && pend[0].t == cyc) begin
            bus_if.mem_rdata = pend[0].val[0];
            void'(pend.pop_front());
        end else begin
            bus_if.mem_rdata = 1'($urandom_range(0, 1));
        end
        if (rst_n && bus_if.mem_rd) pend.push_back('{cyc + LAT, pixel(int'(bus_if.mem_addr))});
    end

    // Monitor: compares reads and responses against the scoreboard queues
    always @(negedge clk) begin
        rd_e  r;
        rsp_e s;
        if (rst_n) begin
            if (bus_if.mem_rd) begin
                if (rd_q.size() == 0) flag("unexpected_mem_rd");
                else begin
                    r = rd_q.pop_front();
                    check("rd_cycle", cyc, r.t);
                    check("rd_addr", int'(bus_if.mem_addr), r.addr);
                end
            end
            if (bus_if.pt_valid) begin
                n_valid++;
                if (rsp_q.size() == 0) flag("unexpected_pt_valid");
                else begin
                    s = rsp_q.pop_front();
                    check("valid_cycle", cyc, s.t);
                    check("pt_value", int'(bus_if.pt_value), s.val);
                    check("oor_cnt", int'(oor_cnt), s.cnt);
                end
                last_val = int'(bus_if.pt_value);
            end else begin
                check("value_hold", int'(bus_if.pt_value), last_val);
            end
        end
    end

    task automatic do_req(input int x, input int y, input bit drop_early);
        int t;
        bit seen;
        @(negedge clk);
        bus_if.pt_req      = 1'b1;
        bus_if.pt_coords_x = 10'(x);
        bus_if.pt_coords_y = 10'(y);
        t = cyc;
        model_issue(t, x, y);
        if (drop_early) begin
            @(negedge clk);
            bus_if.pt_req = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.pt_valid) seen = 1'b1;
        end
        if (!seen) flag("pt_valid_timeout");
        if (!drop_early) begin
            @(negedge clk);
            @(negedge clk);
            bus_if.pt_req = 1'b0;
        end
    endtask

    task automatic rand_coords(output int x, output int y);
        case ($urandom_range(0, 3))
            0: begin
                x = ($urandom_range(0, 1) == 0) ? W - 1 : W;
                y = ($urandom_range(0, 1) == 0) ? H - 1 : H;
            end
            1: begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            default: begin
                x = $urandom_range(0, W - 1);
                y = $urandom_range(0, H - 1);
            end
        endcase
    endtask

    initial begin
        int x, y, t, v0;
        tests = 0; fails = 0; n_valid = 0; oor_model = 0; last_val = 0; cyc = 0;
        rst_n = 1'b0;
        bus_if.pt_req = 1'b0;
        bus_if.pt_coords_x = '0;
        bus_if.pt_coords_y = '0;
        bus_if.mem_rdata = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pt_valid", int'(bus_if.pt_valid), 0);
        check("reset_mem_rd", int'(bus_if.mem_rd), 0);
        check("reset_mem_addr", int'(bus_if.mem_addr), 0);
        check("reset_oor_cnt", int'(oor_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1016, 5, 1'b0);
        check("oor_cnt_after_1016", int'(oor_cnt), 1);
        do_req(10, 2, 1'b0);
        check("value_1290", int'(bus_if.pt_value), 1);

        // Reset three cycles into an access: abandon it, no response
        @(negedge clk);
        bus_if.pt_req = 1'b1;
        bus_if.pt_coords_x = 10'd10;
        bus_if.pt_coords_y = 10'd2;
        t = cyc;
        model_issue(t, 10, 2);
        while (cyc < t + 3) @(negedge clk);
        rst_n = 1'b0;
        bus_if.pt_req = 1'b0;
        #1;
        check("midrst_pt_valid", int'(bus_if.pt_valid), 0);
        check("midrst_pt_value", int'(bus_if.pt_value), 0);
        check("midrst_mem_rd", int'(bus_if.mem_rd), 0);
        check("midrst_mem_addr", int'(bus_if.mem_addr), 0);
        check("midrst_oor_cnt", int'(oor_cnt), 0);
        rd_q.delete();
        rsp_q.delete();
        pend.delete();
        oor_model = 0;
        last_val = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_req(639, 479, 1'b0);
        check("addr_639_479", int'(bus_if.mem_addr), 307199);

        // Early drop: one RELEASE cycle, next request accepted right after
        do_req(20, 30, 1'b1);
        do_req(100, 100, 1'b0);

        v0 = n_valid;
        for (int i = 0; i < 536; i++) begin
            rand_coords(x, y);
            do_req(x, y, 1'b0);
        end
        check("b2b_valid_count", n_valid - v0, 536);

        for (int i = 0; i < 40; i++) begin
            rand_coords(x, y);
            do_req(x, y, 1'($urandom_range(0, 1)));
        end

        // Saturation: preload the counter near its ceiling
        @(negedge clk);
        force dut.oor_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.oor_cnt_q;
        oor_model = 65533;
        do_req(1023, 1023, 1'b0);
        do_req(640, 0, 1'b1);
        do_req(0, 480, 1'b0);
        do_req(1016, 5, 1'b0);
        check("oor_cnt_saturated", int'(oor_cnt), 65535);

        repeat (10) @(negedge clk);
        check("rd_queue_drained", rd_q.size(), 0);
        check("rsp_queue_drained", rsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
